// File: rtl/unidade_busca.sv
// Fetch stage of the multicycle RV32I core: owns PC and IR, runs the imem req/ack
// handshake, slices the IR fields and computes/commits the next PC.
module unidade_busca #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_IR,
   input  logic        load_PC,
   input  logic [1:0]  pc_src,
   input  logic        br_taken,
   input  logic [31:0] imme,
   input  logic [31:0] rs1_data,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic        ir_valid,
   output logic        busy,
   output logic [31:0] pc,
   output logic [31:0] pc_ir,
   output logic [31:0] pc_plus4,
   output logic [31:0] ir,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  funct7,
   output logic        fetch_err,
   output logic        misalign_err
);
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [0:0] {F_IDLE = 1'b0, F_REQ = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, pc_ir_q, pc_ir_d, ir_q, ir_d, addr_q, addr_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ir_valid_q, ir_valid_d, fetch_err_q, fetch_err_d;
   logic        misalign_q, misalign_d, pend_q, pend_d;
   logic [31:0] pc_plus4_s, rel_target_s, jalr_sum_s, target_s;
   logic        target_ok_s, fetch_done_s;

   assign pc_plus4_s = pc_ir_q + 32'd4;

   // Next-PC target; every option is relative to pc_ir except the JALR base.
   always_comb begin
      rel_target_s = pc_ir_q + imme;
      jalr_sum_s   = rs1_data + imme;
      case (pc_src)
         2'b00:   target_s = pc_plus4_s;
         2'b01:   target_s = rel_target_s;
         2'b10:   target_s = {jalr_sum_s[31:1], 1'b0};
         2'b11:   target_s = br_taken ? rel_target_s : pc_plus4_s;
         default: target_s = pc_plus4_s;
      endcase
      target_ok_s = (target_s[1:0] == 2'b00);
   end

   // Fetch FSM next state plus PC/IR/error updates.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_ir_d      = pc_ir_q;
      ir_d         = ir_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      ir_valid_d   = 1'b0;
      fetch_err_d  = fetch_err_q;
      misalign_d   = misalign_q;
      pend_d       = pend_q;
      pend_pc_d    = pend_pc_q;
      fetch_done_s = 1'b0;
      case (state_q)
         F_IDLE: begin
            if (load_IR && !fetch_err_q) begin
               state_d = F_REQ;
               addr_d  = pc_q;
               cnt_d   = 16'd0;
            end else begin
               state_d = F_IDLE;
            end
            if (load_PC && target_ok_s) begin
               pc_d = target_s;
            end else if (load_PC) begin
               misalign_d = 1'b1;
            end else begin
               pc_d = pc_q;
            end
         end
         F_REQ: begin
            if (imem_ack) begin
               ir_d         = imem_rdata;
               pc_ir_d      = addr_q;
               ir_valid_d   = 1'b1;
               state_d      = F_IDLE;
               fetch_done_s = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               fetch_err_d  = 1'b1;
               state_d      = F_IDLE;
               fetch_done_s = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
            if (load_PC && !target_ok_s) begin
               misalign_d = 1'b1;
            end else begin
               misalign_d = misalign_q;
            end
            // A PC commit during a fetch is held back so imem_addr never moves mid-request.
            if (fetch_done_s) begin
               pend_d = 1'b0;
               if (load_PC && target_ok_s) begin
                  pc_d = target_s;
               end else if (pend_q) begin
                  pc_d = pend_pc_q;
               end else begin
                  pc_d = pc_q;
               end
            end else if (load_PC && target_ok_s) begin
               pend_d    = 1'b1;
               pend_pc_d = target_s;
            end else begin
               pend_d = pend_q;
            end
         end
         default: state_d = F_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= F_IDLE;
         pc_q        <= RESET_PC;
         pc_ir_q     <= RESET_PC;
         ir_q        <= NOP;
         addr_q      <= RESET_PC;
         cnt_q       <= 16'd0;
         ir_valid_q  <= 1'b0;
         fetch_err_q <= 1'b0;
         misalign_q  <= 1'b0;
         pend_q      <= 1'b0;
         pend_pc_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pc_ir_q     <= pc_ir_d;
         ir_q        <= ir_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         ir_valid_q  <= ir_valid_d;
         fetch_err_q <= fetch_err_d;
         misalign_q  <= misalign_d;
         pend_q      <= pend_d;
         pend_pc_q   <= pend_pc_d;
      end
   end

   assign imem_req     = (state_q == F_REQ);
   assign busy         = (state_q == F_REQ);
   assign imem_addr    = addr_q;
   assign ir_valid     = ir_valid_q;
   assign pc           = pc_q;
   assign pc_ir        = pc_ir_q;
   assign pc_plus4     = pc_plus4_s;
   assign ir           = ir_q;
   assign opcode       = ir_q[6:0];
   assign rd           = ir_q[11:7];
   assign funct3       = ir_q[14:12];
   assign rs1          = ir_q[19:15];
   assign rs2          = ir_q[24:20];
   assign funct7       = ir_q[31:25];
   assign fetch_err    = fetch_err_q;
   assign misalign_err = misalign_q;
endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed scenarios plus randomized
// fetch / PC-commit sequences checked against an architectural model.
module tb_unidade_busca;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_IR = 1'b0, load_PC = 1'b0, br_taken = 1'b0, imem_ack = 1'b0;
   logic [1:0]  pc_src = 2'd0;
   logic [31:0] imme = 32'd0, rs1_data = 32'd0, imem_rdata = 32'd0;
   logic        imem_req, ir_valid, busy, fetch_err, misalign_err;
   logic [31:0] imem_addr, pc, pc_ir, pc_plus4, ir;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;

   int checks = 0;
   int errors = 0;

   // architectural model
   logic [31:0] m_pc, m_pc_ir, m_ir;
   logic        m_merr;

   always #5 clk = ~clk;

   unidade_busca #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .load_IR(load_IR), .load_PC(load_PC), .pc_src(pc_src),
      .br_taken(br_taken), .imme(imme), .rs1_data(rs1_data), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .ir_valid(ir_valid), .busy(busy), .pc(pc), .pc_ir(pc_ir), .pc_plus4(pc_plus4),
      .ir(ir), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
      .funct7(funct7), .fetch_err(fetch_err), .misalign_err(misalign_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_target(input logic [1:0] src, input logic br,
                                              input logic [31:0] im, input logic [31:0] r1,
                                              input logic [31:0] base);
      logic [31:0] t;
      if (src == 2'd0 || (src == 2'd3 && !br)) t = base + 32'd4;
      else if (src == 2'd2) begin
         t = r1 + im;
         t = t - (t % 32'd2);
      end else t = base + im;
      return t;
   endfunction

   task automatic model_reset();
      m_pc = 32'd0; m_pc_ir = 32'd0; m_ir = 32'h0000_0013; m_merr = 1'b0;
   endtask

   task automatic model_load_pc(input logic [31:0] t);
      if (t % 32'd4 != 32'd0) m_merr = 1'b1;
      else m_pc = t;
   endtask

   task automatic apply_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0; model_reset(); tick();
   endtask

   task automatic do_load_pc(input logic [1:0] src, input logic br,
                             input logic [31:0] im, input logic [31:0] r1);
      pc_src = src; br_taken = br; imme = im; rs1_data = r1;
      model_load_pc(ref_target(src, br, im, r1, m_pc_ir));
      load_PC = 1'b1; tick(); load_PC = 1'b0;
   endtask

   // Fetch driver: load_PC pulses in request cycle lpc_cyc (-1 = never); ends in the ir_valid cycle.
   task automatic do_fetch(input logic [31:0] word, input int delay, input int lpc_cyc);
      logic [31:0] t, old_pc;
      t = ref_target(pc_src, br_taken, imme, rs1_data, m_pc_ir);
      old_pc = m_pc;
      load_IR = 1'b1; tick(); load_IR = 1'b0;
      for (int c = 0; c <= delay; c++) begin
         load_PC = (c == lpc_cyc);
         if (c == delay) begin imem_ack = 1'b1; imem_rdata = word; end
         tick();
         load_PC = 1'b0;
      end
      imem_ack = 1'b0; imem_rdata = $urandom;
      m_ir = word; m_pc_ir = old_pc;
      if (lpc_cyc >= 0) model_load_pc(t);
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick();
      checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
      checks++; if (pc_ir !== 32'd0) begin errors++; $display("FAIL reset_pc_ir got %h exp 0", pc_ir); end
      checks++; if (ir !== 32'h13) begin errors++; $display("FAIL reset_ir got %h exp 00000013", ir); end
      checks++; if ({imem_req, ir_valid, busy, fetch_err, misalign_err} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 00000", {imem_req, ir_valid, busy, fetch_err, misalign_err}); end
      rst = 1'b0; model_reset(); tick();
   endtask

   task automatic test_fetch();
      load_IR = 1'b1; tick(); load_IR = 1'b0;
      checks++; if (imem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fetch_req got %b%b exp 11", imem_req, busy); end
      checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL fetch_addr got %h exp 0", imem_addr); end
      tick(); tick();
      checks++; if (ir_valid !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL fetch_wait valid %b addr %h exp 0/0", ir_valid, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h0050_0093; tick(); imem_ack = 1'b0;
      m_ir = 32'h0050_0093; m_pc_ir = 32'd0;
      checks++; if (ir !== 32'h0050_0093) begin errors++; $display("FAIL fetch_ir got %h exp 00500093", ir); end
      checks++; if (opcode !== 7'h13 || rd !== 5'd1) begin errors++; $display("FAIL fetch_fields got %h/%0d exp 13/1", opcode, rd); end
      checks++; if (ir_valid !== 1'b1 || imem_req !== 1'b0 || pc_ir !== 32'd0) begin
         errors++; $display("FAIL fetch_done valid %b req %b pc_ir %h exp 1/0/0", ir_valid, imem_req, pc_ir); end
      tick();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b exp 0", ir_valid); end
   endtask

   task automatic test_next_pc();
      do_load_pc(2'd0, 1'b0, 32'd0, 32'd0);
      checks++; if (pc !== 32'd4) begin errors++; $display("FAIL npc_plus4 got %h exp 4", pc); end
      do_fetch($urandom, 1, -1);
      do_load_pc(2'd1, 1'b0, 32'hFFFF_FFF8, 32'd0);
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL npc_wrap got %h exp fffffffc", pc); end
      do_load_pc(2'd2, 1'b0, 32'd0, 32'd8);
      do_fetch($urandom, 0, -1);
      checks++; if (pc_ir !== 32'd8 || pc_plus4 !== 32'd12) begin errors++; $display("FAIL npc_pcir got %h/%h exp 8/c", pc_ir, pc_plus4); end
      do_load_pc(2'd3, 1'b0, 32'd16, 32'd0);
      checks++; if (pc !== 32'd12) begin errors++; $display("FAIL npc_br_nt got %h exp c", pc); end
      do_load_pc(2'd3, 1'b1, 32'd16, 32'd0);
      checks++; if (pc !== 32'd24) begin errors++; $display("FAIL npc_br_t got %h exp 18", pc); end
      do_load_pc(2'd2, 1'b0, 32'd3, 32'h101);
      checks++; if (pc !== 32'h104 || misalign_err !== 1'b0) begin errors++; $display("FAIL npc_jalr got %h/%b exp 104/0", pc, misalign_err); end
   endtask

   task automatic test_pending();
      logic [31:0] a0, t;
      a0 = m_pc; t = m_pc_ir + 32'd4;
      pc_src = 2'd0; load_IR = 1'b1; tick(); load_IR = 1'b0;
      load_PC = 1'b1; tick(); load_PC = 1'b0;
      checks++; if (pc !== a0 || imem_addr !== a0) begin errors++; $display("FAIL pend_hold1 pc %h addr %h exp %h", pc, imem_addr, a0); end
      tick();
      checks++; if (pc !== a0 || imem_addr !== a0) begin errors++; $display("FAIL pend_hold2 pc %h addr %h exp %h", pc, imem_addr, a0); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0517; tick(); imem_ack = 1'b0;
      m_pc = t; m_pc_ir = a0; m_ir = 32'h0000_0517;
      checks++; if (pc !== t || pc_ir !== a0 || ir_valid !== 1'b1) begin
         errors++; $display("FAIL pend_apply pc %h pc_ir %h valid %b exp %h/%h/1", pc, pc_ir, ir_valid, t, a0); end
   endtask

   task automatic test_same_cycle();
      logic [31:0] a0, t;
      a0 = m_pc; t = m_pc_ir + 32'h40;
      pc_src = 2'd1; imme = 32'h40;
      load_IR = 1'b1; load_PC = 1'b1; tick(); load_IR = 1'b0; load_PC = 1'b0;
      checks++; if (imem_addr !== a0 || pc !== t) begin errors++; $display("FAIL same_cyc addr %h pc %h exp %h/%h", imem_addr, pc, a0, t); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_006F; tick(); imem_ack = 1'b0;
      m_pc = t; m_pc_ir = a0; m_ir = 32'h0000_006F;
      checks++; if (pc_ir !== a0 || pc !== t) begin errors++; $display("FAIL same_cyc_end pc_ir %h pc %h exp %h/%h", pc_ir, pc, a0, t); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int kind, dly;
         kind = $urandom_range(0, 2);
         dly = $urandom_range(0, 5);
         pc_src = 2'($urandom_range(0, 3)); br_taken = 1'($urandom);
         rs1_data = $urandom;
         imme = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         if (kind == 0) do_load_pc(pc_src, br_taken, imme, rs1_data);
         else do_fetch($urandom, dly, (kind == 2) ? $urandom_range(0, dly) : -1);
         checks++;
         if (pc !== m_pc || pc_ir !== m_pc_ir || ir !== m_ir || misalign_err !== m_merr ||
             pc_plus4 !== m_pc_ir + 32'd4 || ir_valid !== (kind != 0) || imem_req !== 1'b0 ||
             {funct7, rs2, rs1, funct3, rd, opcode} !== m_ir) begin
            errors++;
            $display("FAIL random[%0d] pc %h/%h pc_ir %h/%h ir %h/%h merr %b/%b valid %b req %b",
                     n, pc, m_pc, pc_ir, m_pc_ir, ir, m_ir, misalign_err, m_merr, ir_valid, imem_req);
         end
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      pc_src = 2'd0;
      load_IR = 1'b1; tick(); load_IR = 1'b0;
      for (int c = 0; c < 15; c++) begin
         load_PC = (c == 3);
         tick();
         load_PC = 1'b0;
      end
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || pc !== 32'd0) begin
         errors++; $display("FAIL tmo_early req %b err %b pc %h exp 1/0/0", imem_req, fetch_err, pc); end
      tick();
      checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL tmo_err err %b req %b busy %b exp 1/0/0", fetch_err, imem_req, busy); end
      checks++; if (ir !== 32'h13 || pc_ir !== 32'd0 || ir_valid !== 1'b0 || pc !== 32'd4) begin
         errors++; $display("FAIL tmo_state ir %h pc_ir %h valid %b pc %h exp 13/0/0/4", ir, pc_ir, ir_valid, pc); end
      load_IR = 1'b1; tick(); load_IR = 1'b0;
      checks++; if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin errors++; $display("FAIL tmo_block req %b err %b exp 0/1", imem_req, fetch_err); end
   endtask

   task automatic test_misalign_and_reset();
      apply_reset();
      do_load_pc(2'd1, 1'b0, 32'd2, 32'd0);
      checks++; if (misalign_err !== 1'b1 || pc !== 32'd0) begin errors++; $display("FAIL misalign got %b pc %h exp 1/0", misalign_err, pc); end
      load_IR = 1'b1; tick(); load_IR = 1'b0; tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_pre req got %b exp 1", imem_req); end
      rst = 1'b1; #1;
      checks++; if (imem_req !== 1'b0 || busy !== 1'b0 || misalign_err !== 1'b0) begin
         errors++; $display("FAIL rst_async req %b busy %b merr %b exp 0/0/0", imem_req, busy, misalign_err); end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); rst = 1'b0; tick(); imem_ack = 1'b0; tick();
      checks++; if (ir !== 32'h13 || pc_ir !== 32'd0 || pc !== 32'd0 || ir_valid !== 1'b0) begin
         errors++; $display("FAIL rst_ack ir %h pc_ir %h pc %h valid %b exp 13/0/0/0", ir, pc_ir, pc, ir_valid); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_next_pc();
      test_pending();
      test_same_cycle();
      test_random();
      test_timeout();
      test_misalign_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
